bs_turn_ctrl: RTL



---
 rtl/bs_pkg.sv | 36 +++
 rtl/btn_edge.sv | 29 ++
 rtl/bs_turn_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bs_pkg
//  Description : Shared types and display word codes for the battleship
//                game-flow controller.
//  Revision    : 1.0  initial release
// ============================================================================
package bs_pkg;

  // Game-flow states; explicit 3-bit encoding keeps the register width fixed
  typedef enum logic [2:0] {
    SETUP    = 3'd0,
    TURN_A   = 3'd1,
    BAD_A    = 3'd2,
    SETTLE_A = 3'd3,
    TURN_B   = 3'd4,
    BAD_B    = 3'd5,
    SETTLE_B = 3'd6,
    OVER     = 3'd7
  } state_t;

  // Display word selects; codes 6 and 7 are reserved and never produced
  typedef logic [2:0] disp_t;

  localparam disp_t D_PLACE = 3'd0;
  localparam disp_t D_WAIT  = 3'd1;
  localparam disp_t D_FIRE  = 3'd2;
  localparam disp_t D_BAD   = 3'd3;
  localparam disp_t D_WIN   = 3'd4;
  localparam disp_t D_LOSE  = 3'd5;

  // Width of the message/settle/turn cycle counters
  localparam int unsigned CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Single-flop rising-edge detector for an already debounced
//                button level. Produces a one-cycle pulse per press.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic rise
);

  logic r_btn_q;

  // Remember last cycle's level so a held button is seen as a single rise
  always_ff @(posedge clk) begin
    if (clr) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign rise = btn & ~r_btn_q;

endmodule
`default_nettype wire

// File: rtl/bs_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bs_turn_ctrl
//  Description : Game-flow controller for two battleship boards. Handles ship
//                placement, alternating turns, bad-move messages, attack
//                settling and win/lose detection. All outputs are registered.
//                Optional macro TURN_TIMEOUT_EN adds a per-turn timeout that
//                passes the move to the opponent after TURN_CYCLES cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module bs_turn_ctrl
  import bs_pkg::*;
#(
  parameter int unsigned MSG_CYCLES    = 100_000_000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TURN_CYCLES   = 1_000_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       BTN1A,
  input  logic       BTN1B,
  input  logic       BTN2A,
  input  logic       BTN2B,
  input  logic       OKA,
  input  logic       OKB,
  input  logic       LivA,
  input  logic       LivB,
  output logic       ST,
  output logic       LDR2A,
  output logic       LDR2B,
  output logic [2:0] DispA,
  output logic [2:0] DispB,
  output logic       TurnA
);

  localparam logic [CNT_W-1:0] c_msg_last    = CNT_W'(MSG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);

  // Bit order of the button vector: 0=BTN1A, 1=BTN1B, 2=BTN2A, 3=BTN2B
  logic [3:0] w_btn;
  logic [3:0] w_rise;

  assign w_btn = {BTN2B, BTN2A, BTN1B, BTN1A};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_edge u_edge (
      .clk  (clk),
      .clr  (clr),
      .btn  (w_btn[i]),
      .rise (w_rise[i])
    );
  end

  logic w_place_a, w_place_b, w_fire_a, w_fire_b;
  assign w_place_a = w_rise[0];
  assign w_place_b = w_rise[1];
  assign w_fire_a  = w_rise[2];
  assign w_fire_b  = w_rise[3];

  state_t           r_state,    w_state_nxt;
  logic             r_placed_a, w_placed_a_nxt;
  logic             r_placed_b, w_placed_b_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic             r_st,       w_st_nxt;
  logic             r_ldr2a,    w_ldr2a_nxt;
  logic             r_ldr2b,    w_ldr2b_nxt;
  disp_t            r_disp_a,   w_disp_a_nxt;
  disp_t            r_disp_b,   w_disp_b_nxt;
  logic             r_turn_a,   w_turn_a_nxt;

`ifdef TURN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_turn_last = CNT_W'(TURN_CYCLES - 1);
  logic [CNT_W-1:0] r_turn_cnt, w_turn_cnt_nxt;
`else
  logic w_unused_turn_cycles;
  assign w_unused_turn_cycles = ^TURN_CYCLES;
`endif

  // Next-state and next-output decode; registers hold unless a state acts
  always_comb begin
    w_state_nxt    = r_state;
    w_placed_a_nxt = r_placed_a;
    w_placed_b_nxt = r_placed_b;
    w_cnt_nxt      = r_cnt;
    w_st_nxt       = r_st;
    w_ldr2a_nxt    = 1'b0;
    w_ldr2b_nxt    = 1'b0;
    w_disp_a_nxt   = r_disp_a;
    w_disp_b_nxt   = r_disp_b;
    w_turn_a_nxt   = r_turn_a;
`ifdef TURN_TIMEOUT_EN
    w_turn_cnt_nxt = '0;
`endif

    unique case (r_state)
      SETUP: begin
        if (r_placed_a && r_placed_b) begin
          w_state_nxt  = TURN_A;
          w_st_nxt     = 1'b1;
          w_disp_a_nxt = D_FIRE;
          w_disp_b_nxt = D_WAIT;
          w_turn_a_nxt = 1'b1;
        end else begin
          if (w_place_a) begin
            w_placed_a_nxt = 1'b1;
            w_disp_a_nxt   = D_WAIT;
          end
          if (w_place_b) begin
            w_placed_b_nxt = 1'b1;
            w_disp_b_nxt   = D_WAIT;
          end
        end
      end

      TURN_A: begin
        // Re-assert steady displays so a one-cycle timeout message clears
        w_disp_a_nxt = D_FIRE;
        w_disp_b_nxt = D_WAIT;
        w_turn_a_nxt = 1'b1;
        if (w_fire_a) begin
          w_cnt_nxt = '0;
          if (OKB) begin
            w_ldr2a_nxt = 1'b1;
            w_state_nxt = SETTLE_A;
          end else begin
            w_state_nxt  = BAD_A;
            w_disp_a_nxt = D_BAD;
          end
        end
`ifdef TURN_TIMEOUT_EN
        else if (r_turn_cnt == c_turn_last) begin
          w_state_nxt  = TURN_B;
          w_disp_a_nxt = D_BAD;
          w_disp_b_nxt = D_FIRE;
          w_turn_a_nxt = 1'b0;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt + CNT_W'(1);
        end
`endif
      end

      BAD_A: begin
        if (r_cnt == c_msg_last) begin
          w_state_nxt  = TURN_A;
          w_disp_a_nxt = D_FIRE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      SETTLE_A: begin
        // LivB is only trusted once the attack load has propagated
        if (r_cnt == c_settle_last) begin
          w_turn_a_nxt = 1'b0;
          if (!LivB) begin
            w_state_nxt  = OVER;
            w_disp_a_nxt = D_WIN;
            w_disp_b_nxt = D_LOSE;
          end else begin
            w_state_nxt  = TURN_B;
            w_disp_a_nxt = D_WAIT;
            w_disp_b_nxt = D_FIRE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      TURN_B: begin
        w_disp_a_nxt = D_WAIT;
        w_disp_b_nxt = D_FIRE;
        w_turn_a_nxt = 1'b0;
        if (w_fire_b) begin
          w_cnt_nxt = '0;
          if (OKA) begin
            w_ldr2b_nxt = 1'b1;
            w_state_nxt = SETTLE_B;
          end else begin
            w_state_nxt  = BAD_B;
            w_disp_b_nxt = D_BAD;
          end
        end
`ifdef TURN_TIMEOUT_EN
        else if (r_turn_cnt == c_turn_last) begin
          w_state_nxt  = TURN_A;
          w_disp_a_nxt = D_FIRE;
          w_disp_b_nxt = D_BAD;
          w_turn_a_nxt = 1'b1;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt + CNT_W'(1);
        end
`endif
      end

      BAD_B: begin
        if (r_cnt == c_msg_last) begin
          w_state_nxt  = TURN_B;
          w_disp_b_nxt = D_FIRE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      SETTLE_B: begin
        if (r_cnt == c_settle_last) begin
          if (!LivA) begin
            w_state_nxt  = OVER;
            w_disp_a_nxt = D_LOSE;
            w_disp_b_nxt = D_WIN;
            w_turn_a_nxt = 1'b0;
          end else begin
            w_state_nxt  = TURN_A;
            w_disp_a_nxt = D_FIRE;
            w_disp_b_nxt = D_WAIT;
            w_turn_a_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      OVER: begin
        // Terminal until clr: everything holds, strobes stay low
      end

      default: begin
        w_state_nxt = SETUP;
      end
    endcase
  end

  // State, flag, counter and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= SETUP;
      r_placed_a <= 1'b0;
      r_placed_b <= 1'b0;
      r_cnt      <= '0;
      r_st       <= 1'b0;
      r_ldr2a    <= 1'b0;
      r_ldr2b    <= 1'b0;
      r_disp_a   <= D_PLACE;
      r_disp_b   <= D_PLACE;
      r_turn_a   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_placed_a <= w_placed_a_nxt;
      r_placed_b <= w_placed_b_nxt;
      r_cnt      <= w_cnt_nxt;
      r_st       <= w_st_nxt;
      r_ldr2a    <= w_ldr2a_nxt;
      r_ldr2b    <= w_ldr2b_nxt;
      r_disp_a   <= w_disp_a_nxt;
      r_disp_b   <= w_disp_b_nxt;
      r_turn_a   <= w_turn_a_nxt;
    end
  end

`ifdef TURN_TIMEOUT_EN
  // Turn-length counter; only advances while a player is on the move
  always_ff @(posedge clk) begin
    if (clr) begin
      r_turn_cnt <= '0;
    end else begin
      r_turn_cnt <= w_turn_cnt_nxt;
    end
  end
`endif

  assign ST    = r_st;
  assign LDR2A = r_ldr2a;
  assign LDR2B = r_ldr2b;
  assign DispA = r_disp_a;
  assign DispB = r_disp_b;
  assign TurnA = r_turn_a;

endmodule
`default_nettype wire
